// File: rtl/nco_pkg.sv
// Shared opcodes, write-select encodings and FSM state type for the NCO frame controller.
package nco_pkg;

  localparam logic [3:0] NCO_OP_TUNE   = 4'h1;
  localparam logic [3:0] NCO_OP_WAVE   = 4'h2;
  localparam logic [3:0] NCO_OP_UPDATE = 4'h3;

  localparam logic WR_SEL_TUNE = 1'b0;
  localparam logic WR_SEL_WAVE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_WRITE,
    ST_WAIT_END,
    ST_DRAIN
  } nco_state_e;

endpackage

// File: rtl/nco_frame_controller.sv
// Turns chip-select-delimited SPI byte frames into NCO bank register writes and update strobes.
// Optional NCO_CTRL_ERR_COUNT_EN adds a saturating 8-bit count of rejected frames (o_err_count).
module nco_frame_controller
  import nco_pkg::*;
#(
  parameter int NUM_NCO  = 8,
  parameter int TW_WIDTH = 24
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_frame_start,
  input  logic                i_frame_end,
  input  logic                i_byte_valid,
  input  logic [7:0]          i_byte,
  output logic                o_wr_valid,
  input  logic                i_wr_ready,
  output logic                o_wr_sel,
  output logic [3:0]          o_wr_addr,
  output logic [TW_WIDTH-1:0] o_wr_data,
  output logic                o_update,
  output logic                o_frame_err
`ifdef NCO_CTRL_ERR_COUNT_EN
  ,
  output logic [7:0]          o_err_count
`endif
);

  localparam int TW_BYTES = TW_WIDTH / 8;
  localparam int CNT_W    = $clog2(TW_BYTES) + 1;
  localparam logic [CNT_W-1:0] TUNE_LAST = CNT_W'(TW_BYTES - 1);

  nco_state_e          state_q, state_d;
  nco_state_e          dest_q, dest_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_sel_q, wr_sel_d;
  logic [3:0]          wr_addr_q, wr_addr_d;
  logic [TW_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                upd_pend_q, upd_pend_d;
  logic                update_q, update_d;
  logic                frame_err_q, frame_err_d;

  logic [3:0] opcode;
  logic [3:0] index;
  logic       idx_ok;
  logic       last_byte;

  assign opcode    = i_byte[7:4];
  assign index     = i_byte[3:0];
  assign idx_ok    = int'(index) < NUM_NCO;
  assign last_byte = (wr_sel_q == WR_SEL_WAVE) ? (cnt_q == '0) : (cnt_q == TUNE_LAST);

  always_comb begin
    state_d     = state_q;
    dest_d      = dest_q;
    cnt_d       = cnt_q;
    wr_sel_d    = wr_sel_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    upd_pend_d  = upd_pend_q;
    update_d    = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: if (i_frame_start) state_d = ST_CMD;
      ST_WRITE: begin
        // A stalled write always completes; frame events only steer where it lands afterwards.
        if (i_frame_start) dest_d = ST_CMD;
        if (i_byte_valid && dest_d != ST_DRAIN) begin
          dest_d      = ST_DRAIN;
          frame_err_d = 1'b1;
        end
        if (i_frame_end) dest_d = ST_IDLE;
        if (i_wr_ready) state_d = dest_d;
      end
      default: begin
        if (i_frame_start) begin
          state_d = ST_CMD;
        end else begin
          if (i_byte_valid) begin
            case (state_q)
              ST_CMD: begin
                if ((opcode == NCO_OP_TUNE || opcode == NCO_OP_WAVE) && idx_ok) begin
                  state_d   = ST_DATA;
                  wr_sel_d  = (opcode == NCO_OP_WAVE) ? WR_SEL_WAVE : WR_SEL_TUNE;
                  wr_addr_d = index;
                  wr_data_d = '0;
                  cnt_d     = '0;
                end else if (opcode == NCO_OP_UPDATE && idx_ok) begin
                  state_d    = ST_WAIT_END;
                  upd_pend_d = 1'b1;
                end else begin
                  state_d     = ST_DRAIN;
                  frame_err_d = 1'b1;
                end
              end
              ST_DATA: begin
                wr_data_d = (wr_sel_q == WR_SEL_WAVE) ? TW_WIDTH'(i_byte[1:0])
                                                      : ((wr_data_q << 8) | TW_WIDTH'(i_byte));
                cnt_d     = cnt_q + CNT_W'(1);
                if (last_byte) begin
                  state_d = ST_WRITE;
                  dest_d  = ST_WAIT_END;
                end
              end
              ST_WAIT_END: begin
                state_d     = ST_DRAIN;
                frame_err_d = 1'b1;
                upd_pend_d  = 1'b0;
              end
              default: ;
            endcase
          end
          // Frame end is applied after any byte seen in the same cycle.
          if (i_frame_end) begin
            case (state_d)
              ST_CMD:   state_d = ST_IDLE;
              ST_DATA: begin
                state_d     = ST_IDLE;
                frame_err_d = 1'b1;
              end
              ST_WRITE: dest_d = ST_IDLE;
              ST_WAIT_END: begin
                state_d    = ST_IDLE;
                update_d   = upd_pend_d;
                upd_pend_d = 1'b0;
              end
              ST_DRAIN: state_d = ST_IDLE;
              default: ;
            endcase
          end
        end
      end
    endcase

    if (state_d == ST_CMD) begin
      cnt_d      = '0;
      upd_pend_d = 1'b0;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      dest_q      <= ST_WAIT_END;
      cnt_q       <= '0;
      wr_sel_q    <= WR_SEL_TUNE;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      upd_pend_q  <= 1'b0;
      update_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dest_q      <= dest_d;
      cnt_q       <= cnt_d;
      wr_sel_q    <= wr_sel_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      upd_pend_q  <= upd_pend_d;
      update_q    <= update_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Decoded from state so an asynchronous reset drops the request immediately.
  assign o_wr_valid  = (state_q == ST_WRITE);
  assign o_wr_sel    = wr_sel_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_update    = update_q;
  assign o_frame_err = frame_err_q;

`ifdef NCO_CTRL_ERR_COUNT_EN
  logic [7:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (frame_err_d && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) err_count_q <= '0;
    else            err_count_q <= err_count_d;
  end

  assign o_err_count = err_count_q;
`endif

endmodule

// File: tb/tb_nco_frame_controller.sv
// Randomized self-checking bench for nco_frame_controller against a frame-level reference model.
module tb_nco_frame_controller;

  localparam int NUM_NCO  = 8;
  localparam int TW_WIDTH = 24;
  localparam int TW_BYTES = TW_WIDTH / 8;

  logic                i_clock = 1'b0;
  logic                i_reset_n = 1'b0;
  logic                i_frame_start = 1'b0;
  logic                i_frame_end = 1'b0;
  logic                i_byte_valid = 1'b0;
  logic [7:0]          i_byte = 8'h00;
  logic                o_wr_valid;
  logic                i_wr_ready = 1'b0;
  logic                o_wr_sel;
  logic [3:0]          o_wr_addr;
  logic [TW_WIDTH-1:0] o_wr_data;
  logic                o_update;
  logic                o_frame_err;
`ifdef NCO_CTRL_ERR_COUNT_EN
  logic [7:0]          o_err_count;
`endif

  nco_frame_controller #(.NUM_NCO(NUM_NCO), .TW_WIDTH(TW_WIDTH)) dut (
    .i_clock       (i_clock),
    .i_reset_n     (i_reset_n),
    .i_frame_start (i_frame_start),
    .i_frame_end   (i_frame_end),
    .i_byte_valid  (i_byte_valid),
    .i_byte        (i_byte),
    .o_wr_valid    (o_wr_valid),
    .i_wr_ready    (i_wr_ready),
    .o_wr_sel      (o_wr_sel),
    .o_wr_addr     (o_wr_addr),
    .o_wr_data     (o_wr_data),
    .o_update      (o_update),
    .o_frame_err   (o_frame_err)
`ifdef NCO_CTRL_ERR_COUNT_EN
    ,
    .o_err_count   (o_err_count)
`endif
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    int     n_wr;
    int     sel;
    int     addr;
    longint data;
    int     n_upd;
    int     n_err;
  } exp_t;

  int  n_checks = 0;
  int  n_errors = 0;
  int  mon_err  = 0;
  int  mon_upd  = 0;
  logic [39:0] wr_q[$];
  bit   ready_rand  = 1'b0;
  logic ready_force = 1'b1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observed writes, update pulses and error pulses, sampled mid-cycle.
  always @(negedge i_clock) begin
    if (i_reset_n) begin
      if (o_wr_valid && i_wr_ready) wr_q.push_back({3'b000, o_wr_sel, o_wr_addr, 32'(o_wr_data)});
      if (o_update)    mon_upd++;
      if (o_frame_err) mon_err++;
    end
  end

  // Reference: outcome of one complete frame computed from its byte list.
  function automatic exp_t model(input logic [7:0] b[$]);
    exp_t e;
    int op, idx, need, n;
    e.n_wr = 0; e.sel = 0; e.addr = 0; e.data = 0; e.n_upd = 0; e.n_err = 0;
    n = b.size();
    if (n == 0) return e;
    op  = int'(b[0]) / 16;
    idx = int'(b[0]) % 16;
    if (idx >= NUM_NCO || op < 1 || op > 3) begin
      e.n_err = 1;
      return e;
    end
    if (op == 3) begin
      if (n == 1) e.n_upd = 1;
      else        e.n_err = 1;
      return e;
    end
    need = (op == 1) ? TW_BYTES : 1;
    if (n - 1 < need) begin
      e.n_err = 1;
      return e;
    end
    e.n_wr = 1;
    e.sel  = (op == 2) ? 1 : 0;
    e.addr = idx;
    if (op == 1) for (int i = 1; i <= need; i++) e.data = e.data * 256 + longint'(b[i]);
    else         e.data = longint'(b[1]) % 4;
    if (n - 1 > need) e.n_err = 1;
    return e;
  endfunction

  task automatic cycle();
    @(posedge i_clock);
    #1;
    i_byte_valid  = 1'b0;
    i_frame_start = 1'b0;
    i_frame_end   = 1'b0;
    i_wr_ready    = ready_rand ? ($urandom_range(0, 99) < 60) : ready_force;
  endtask

  task automatic force_ready(input logic r);
    ready_rand  = 1'b0;
    ready_force = r;
    i_wr_ready  = r;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_end);
    i_byte       = b;
    i_byte_valid = 1'b1;
    i_frame_end  = with_end;
    cycle();
  endtask

  task automatic pulse_start();
    i_frame_start = 1'b1;
    cycle();
  endtask

  task automatic pulse_end();
    i_frame_end = 1'b1;
    cycle();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && o_wr_valid; i++) cycle();
    check("wr_drains", o_wr_valid, 0);
    cycle();
    cycle();
  endtask

  task automatic check_frame(input logic [7:0] b[$], input int err0, input int upd0,
                             input int wr0, input string tag);
    exp_t e;
    e = model(b);
    check({tag, "_err"}, mon_err - err0, e.n_err);
    check({tag, "_upd"}, mon_upd - upd0, e.n_upd);
    check({tag, "_nwr"}, wr_q.size() - wr0, e.n_wr);
    if (e.n_wr == 1 && wr_q.size() > wr0) begin
      check({tag, "_sel"},  wr_q[wr0][36],    e.sel);
      check({tag, "_addr"}, wr_q[wr0][35:32], e.addr);
      check({tag, "_data"}, wr_q[wr0][31:0],  e.data);
    end
  endtask

  task automatic run_frame(input logic [7:0] b[$], input bit merge_end, input string tag);
    int err0, upd0, wr0, n;
    err0 = mon_err; upd0 = mon_upd; wr0 = wr_q.size(); n = b.size();
    pulse_start();
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) cycle();
      send_byte(b[i], merge_end && (i == n - 1));
    end
    if (!(merge_end && n > 0)) pulse_end();
    wait_idle();
    check_frame(b, err0, upd0, wr0, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fb[$];
    int err0, upd0, wr0, err_base, op, idx, kind, r, need;

    #12;
    check("rst_wr_valid", o_wr_valid, 0);
    check("rst_update",   o_update, 0);
    check("rst_frame_err", o_frame_err, 0);
    check("rst_wr_sel",   o_wr_sel, 0);
    check("rst_wr_addr",  o_wr_addr, 0);
    check("rst_wr_data",  o_wr_data, 0);
    @(posedge i_clock);
    #1 i_reset_n = 1'b1;
    err_base = mon_err;
    force_ready(1'b1);
    cycle();

    // Tuning write, ready high: one-cycle request the cycle after the last byte.
    err0 = mon_err; upd0 = mon_upd; wr0 = wr_q.size();
    fb = '{8'h13, 8'h12, 8'h34, 8'h56};
    pulse_start();
    foreach (fb[i]) send_byte(fb[i], 1'b0);
    check("tune_vld_rise", o_wr_valid, 1);
    check("tune_addr", o_wr_addr, 3);
    check("tune_sel",  o_wr_sel, 0);
    check("tune_data", o_wr_data, 24'h123456);
    cycle();
    check("tune_vld_one", o_wr_valid, 0);
    pulse_end();
    wait_idle();
    check_frame(fb, err0, upd0, wr0, "tune");

    // Waveform write under 5 cycles of backpressure.
    force_ready(1'b0);
    err0 = mon_err; upd0 = mon_upd; wr0 = wr_q.size();
    fb = '{8'h25, 8'h02};
    pulse_start();
    foreach (fb[i]) send_byte(fb[i], 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_vld",  o_wr_valid, 1);
      check("bp_addr", o_wr_addr, 5);
      check("bp_sel",  o_wr_sel, 1);
      check("bp_data", o_wr_data, 2);
      cycle();
    end
    force_ready(1'b1);
    check("bp_vld_last", o_wr_valid, 1);
    check("bp_data_last", o_wr_data, 2);
    cycle();
    check("bp_vld_drop", o_wr_valid, 0);
    pulse_end();
    wait_idle();
    check_frame(fb, err0, upd0, wr0, "bp");

    // Update frame: one-cycle pulse after frame end.
    err0 = mon_err; upd0 = mon_upd; wr0 = wr_q.size();
    fb = '{8'h30};
    pulse_start();
    send_byte(8'h30, 1'b0);
    check("upd_early", o_update, 0);
    pulse_end();
    check("upd_pulse", o_update, 1);
    cycle();
    check("upd_one", o_update, 0);
    wait_idle();
    check_frame(fb, err0, upd0, wr0, "upd");

    // Truncated, illegal-index and empty frames.
    fb = '{8'h11, 8'hAA};
    run_frame(fb, 1'b0, "trunc");
    fb = '{8'h19, 8'h13, 8'h12, 8'h34, 8'h56};
    run_frame(fb, 1'b0, "badidx");
    fb.delete();
    run_frame(fb, 1'b0, "empty");

    // Overrun: a byte lands while the write is stalled.
    force_ready(1'b0);
    err0 = mon_err; upd0 = mon_upd; wr0 = wr_q.size();
    fb = '{8'h14, 8'hAB, 8'hCD, 8'hEF, 8'h77};
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(fb[i], 1'b0);
    cycle();
    cycle();
    send_byte(8'h77, 1'b0);
    check("ovr_err_pulse", o_frame_err, 1);
    check("ovr_vld_held", o_wr_valid, 1);
    force_ready(1'b1);
    cycle();
    check("ovr_vld_drop", o_wr_valid, 0);
    pulse_end();
    wait_idle();
    check_frame(fb, err0, upd0, wr0, "ovr");
    fb = '{8'h16, 8'h01, 8'h02, 8'h03};
    run_frame(fb, 1'b0, "after_ovr");

    // Asynchronous reset while a write is stalled.
    force_ready(1'b0);
    pulse_start();
    send_byte(8'h21, 1'b0);
    send_byte(8'h03, 1'b0);
    check("rstw_vld_before", o_wr_valid, 1);
    #2 i_reset_n = 1'b0;
    #1;
    check("rstw_vld_drop", o_wr_valid, 0);
    check("rstw_addr", o_wr_addr, 0);
    check("rstw_data", o_wr_data, 0);
    repeat (2) @(posedge i_clock);
    #1 i_reset_n = 1'b1;
    err_base = mon_err;
    force_ready(1'b1);
    cycle();
    fb = '{8'h27, 8'hFF};
    run_frame(fb, 1'b0, "after_rst");

    // Randomized frames with random backpressure.
    ready_rand = 1'b1;
    for (int f = 0; f < 40; f++) begin
      fb.delete();
      kind = $urandom_range(0, 5);
      idx  = $urandom_range(0, NUM_NCO - 1);
      case (kind)
        0, 1: op = 1;
        2:    op = 2;
        3:    op = 3;
        4: begin
          op = $urandom_range(0, 12);
          if (op >= 1) op = op + 3;
        end
        default: begin
          op  = $urandom_range(1, 3);
          idx = $urandom_range(NUM_NCO, 15);
        end
      endcase
      fb.push_back(8'(op * 16 + idx));
      need = (op == 1) ? TW_BYTES : ((op == 2) ? 1 : 0);
      r = $urandom_range(0, 9);
      if (r < 2)      need = (need > 0) ? $urandom_range(0, need - 1) : need;
      else if (r < 4) need = need + $urandom_range(1, 2);
      for (int i = 0; i < need; i++) fb.push_back(8'($urandom_range(0, 255)));
      if (r == 9) fb.delete();
      run_frame(fb, ($urandom_range(0, 3) == 0), "rand");
    end

`ifdef NCO_CTRL_ERR_COUNT_EN
    check("errcnt_track", o_err_count, (mon_err - err_base > 255) ? 255 : mon_err - err_base);
    force_ready(1'b1);
    for (int i = 0; i < 300; i++) begin
      pulse_start();
      send_byte(8'hF0, 1'b1);
    end
    cycle();
    check("errcnt_sat", o_err_count, 8'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
